// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter sharing one memory bus between instruction fetch and load/store.
// Each access is a registered request/ready handshake with timeout and fetch-starvation bound.
module memory_bus_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT         = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inst_request,
  input  logic [ADDRESS_WIDTH-1:0]  inst_address,
  output logic [DATA_WIDTH-1:0]     inst_read_data,
  output logic                      inst_ready,
  output logic                      inst_error,
  input  logic                      data_request,
  input  logic                      data_write_enable,
  input  logic [DATA_WIDTH/8-1:0]   data_select,
  input  logic [ADDRESS_WIDTH-1:0]  data_address,
  input  logic [DATA_WIDTH-1:0]     data_write_data,
  output logic [DATA_WIDTH-1:0]     data_read_data,
  output logic                      data_ready,
  output logic                      data_error,
  output logic                      bus_request,
  output logic                      bus_write_enable,
  output logic [DATA_WIDTH/8-1:0]   bus_select,
  output logic [ADDRESS_WIDTH-1:0]  bus_address,
  output logic [DATA_WIDTH-1:0]     bus_write_data,
  input  logic [DATA_WIDTH-1:0]     bus_read_data,
  input  logic                      bus_ready,
  output logic                      stall
);

  localparam int SEL_W    = DATA_WIDTH / 8;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int CNT_W    = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t                   r_state, w_stateNext;
  logic                     r_ownerData, w_ownerDataNext;
  logic [STREAK_W-1:0]      r_streak, w_streakNext;
  logic [CNT_W-1:0]         r_count, w_countNext;

  logic [DATA_WIDTH-1:0]    r_instReadData, w_instReadDataNext;
  logic                     r_instReady, w_instReadyNext;
  logic                     r_instError, w_instErrorNext;
  logic [DATA_WIDTH-1:0]    r_dataReadData, w_dataReadDataNext;
  logic                     r_dataReady, w_dataReadyNext;
  logic                     r_dataError, w_dataErrorNext;
  logic                     r_busRequest, w_busRequestNext;
  logic                     r_busWriteEnable, w_busWriteEnableNext;
  logic [SEL_W-1:0]         r_busSelect, w_busSelectNext;
  logic [ADDRESS_WIDTH-1:0] r_busAddress, w_busAddressNext;
  logic [DATA_WIDTH-1:0]    r_busWriteData, w_busWriteDataNext;

  logic w_streakFull;
  logic w_grantInst;

  // Fetch only wins when data has already used up its allowance of back-to-back grants.
  assign w_streakFull = (r_streak == STREAK_W'(MAX_DATA_STREAK));
  assign w_grantInst  = inst_request & (~data_request | w_streakFull);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_ownerData      <= 1'b0;
      r_streak         <= '0;
      r_count          <= '0;
      r_instReadData   <= '0;
      r_instReady      <= 1'b0;
      r_instError      <= 1'b0;
      r_dataReadData   <= '0;
      r_dataReady      <= 1'b0;
      r_dataError      <= 1'b0;
      r_busRequest     <= 1'b0;
      r_busWriteEnable <= 1'b0;
      r_busSelect      <= '0;
      r_busAddress     <= '0;
      r_busWriteData   <= '0;
    end else begin
      r_state          <= w_stateNext;
      r_ownerData      <= w_ownerDataNext;
      r_streak         <= w_streakNext;
      r_count          <= w_countNext;
      r_instReadData   <= w_instReadDataNext;
      r_instReady      <= w_instReadyNext;
      r_instError      <= w_instErrorNext;
      r_dataReadData   <= w_dataReadDataNext;
      r_dataReady      <= w_dataReadyNext;
      r_dataError      <= w_dataErrorNext;
      r_busRequest     <= w_busRequestNext;
      r_busWriteEnable <= w_busWriteEnableNext;
      r_busSelect      <= w_busSelectNext;
      r_busAddress     <= w_busAddressNext;
      r_busWriteData   <= w_busWriteDataNext;
    end
  end

  always_comb begin
    w_stateNext          = r_state;
    w_ownerDataNext      = r_ownerData;
    w_streakNext         = r_streak;
    w_countNext          = r_count;
    w_instReadDataNext   = r_instReadData;
    w_instReadyNext      = 1'b0;
    w_instErrorNext      = 1'b0;
    w_dataReadDataNext   = r_dataReadData;
    w_dataReadyNext      = 1'b0;
    w_dataErrorNext      = 1'b0;
    w_busRequestNext     = r_busRequest;
    w_busWriteEnableNext = r_busWriteEnable;
    w_busSelectNext      = r_busSelect;
    w_busAddressNext     = r_busAddress;
    w_busWriteDataNext   = r_busWriteData;

    case (r_state)
      S_IDLE: begin
        if (inst_request | data_request) begin
          w_stateNext      = S_ACCESS;
          w_countNext      = '0;
          w_busRequestNext = 1'b1;
          if (w_grantInst) begin
            w_ownerDataNext      = 1'b0;
            w_streakNext         = '0;
            w_busWriteEnableNext = 1'b0;
            w_busSelectNext      = '1;
            w_busAddressNext     = inst_address;
            w_busWriteDataNext   = '0;
          end else begin
            w_ownerDataNext      = 1'b1;
            w_busWriteEnableNext = data_write_enable;
            w_busSelectNext      = data_select;
            w_busAddressNext     = data_address;
            w_busWriteDataNext   = data_write_data;
            // The streak only grows while a fetch is actually being held off.
            if (!inst_request)
              w_streakNext = '0;
            else if (!w_streakFull)
              w_streakNext = r_streak + STREAK_W'(1);
          end
        end
      end

      S_ACCESS: begin
        if (bus_ready || (r_count == CNT_W'(TIMEOUT - 1))) begin
          w_stateNext          = S_RESPOND;
          w_busRequestNext     = 1'b0;
          w_busWriteEnableNext = 1'b0;
          w_busSelectNext      = '0;
          w_busAddressNext     = '0;
          w_busWriteDataNext   = '0;
          if (r_ownerData) begin
            w_dataReadyNext    = 1'b1;
            w_dataErrorNext    = ~bus_ready;
            w_dataReadDataNext = bus_ready ? bus_read_data : '0;
          end else begin
            w_instReadyNext    = 1'b1;
            w_instErrorNext    = ~bus_ready;
            w_instReadDataNext = bus_ready ? bus_read_data : '0;
          end
        end else begin
          w_countNext = r_count + CNT_W'(1);
        end
      end

      S_RESPOND: begin
        w_stateNext = S_IDLE;
      end

      default: begin
        w_stateNext          = S_IDLE;
        w_busRequestNext     = 1'b0;
        w_busWriteEnableNext = 1'b0;
        w_busSelectNext      = '0;
        w_busAddressNext     = '0;
        w_busWriteDataNext   = '0;
      end
    endcase
  end

  assign inst_read_data   = r_instReadData;
  assign inst_ready       = r_instReady;
  assign inst_error       = r_instError;
  assign data_read_data   = r_dataReadData;
  assign data_ready       = r_dataReady;
  assign data_error       = r_dataError;
  assign bus_request      = r_busRequest;
  assign bus_write_enable = r_busWriteEnable;
  assign bus_select       = r_busSelect;
  assign bus_address      = r_busAddress;
  assign bus_write_data   = r_busWriteData;

  // Stall is forced low while reset is held so every output reads 0 in reset.
  assign stall = reset & ((inst_request & ~r_instReady) | (data_request & ~r_dataReady));

endmodule
